// File: rtl/sdram_pkg.sv
// sdram_pkg: shared burst length, SDRAM address split, FSM encodings and address helper.
package sdram_pkg;
  localparam int BURST_LEN = 8;
  localparam int BANK_MSB = 19;
  localparam int BANK_LSB = 18;
  localparam int ROW_MSB = 17;
  localparam int ROW_LSB = 8;
  localparam int COL_MSB = 7;
  localparam int COL_LSB = 0;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_DATA, W_END} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} r_state_t;
  function automatic logic [19:0] burst_addr(input logic [16:0] b);
    return {b, 3'b000};
  endfunction
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous first-word-fall-through FIFO with exact occupancy count.
module sample_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clr,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign wr = push & ~full & ~clr;
  assign rd = pop & ~empty & ~clr;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/sdram_sample_buf.sv
// sdram_sample_buf: buffers samples into 8-word SDRAM ring bursts and serves host burst reads.
module sdram_sample_buf
  import sdram_pkg::*;
#(
  parameter int FIFO_DEPTH = 32,
  parameter int RING_BURSTS = 131072
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  input  logic        clr,
  input  logic        h_rreq,
  input  logic [16:0] h_rburst,
  output logic        h_rbusy,
  output logic        h_rd_en,
  output logic [15:0] h_rd_da,
  output logic        u_wreq,
  input  logic        u_wack,
  input  logic        u_wr_da_en,
  output logic [19:0] u_wadr,
  output logic [15:0] u_wr_da,
  output logic        u_rreq,
  input  logic        u_rack,
  output logic [19:0] u_radr,
  input  logic        u_rd_da_en,
  input  logic [15:0] u_rd_da,
  output logic [16:0] wr_burst,
  output logic        overflow,
  output logic        wrapped
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [16:0] LAST_BURST = 17'(RING_BURSTS - 1);
  w_state_t w_state;
  r_state_t r_state;
  logic [CW-1:0] count;
  logic [15:0] head;
  logic [2:0] w_beat, r_beat;
  logic full, empty, pop, clr_pend, do_clr, rd_en_q;
  assign pop = (w_state == W_DATA) & u_wr_da_en;
  // clear is held off until the write FSM is idle so an accepted burst always completes
  assign do_clr = (w_state == W_IDLE) & (clr | clr_pend);
  assign u_wr_da = empty ? '0 : head;
  sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_fifo (
    .clk(clk), .reset_n(reset_n), .clr(do_clr), .push(s_valid), .pop(pop),
    .din(s_data), .dout(head), .count(count), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      w_state <= W_IDLE;
      u_wreq <= 1'b0;
      u_wadr <= '0;
      w_beat <= '0;
      wr_burst <= '0;
      wrapped <= 1'b0;
      overflow <= 1'b0;
      clr_pend <= 1'b0;
    end else begin
      overflow <= do_clr ? 1'b0 : overflow | (s_valid & full);
      clr_pend <= (w_state != W_IDLE) & (clr | clr_pend);
      case (w_state)
        W_IDLE:
          if (do_clr) begin
            wr_burst <= '0;
            wrapped <= 1'b0;
          end else if (count >= CW'(BURST_LEN)) begin
            u_wadr <= burst_addr(wr_burst);
            u_wreq <= 1'b1;
            w_state <= W_REQ;
          end
        W_REQ:
          if (u_wack) begin
            u_wreq <= 1'b0;
            w_beat <= '0;
            w_state <= W_DATA;
          end
        W_DATA:
          if (u_wr_da_en) begin
            w_beat <= w_beat + 3'd1;
            if (w_beat == 3'(BURST_LEN - 1)) w_state <= W_END;
          end
        W_END:
          if (!u_wr_da_en) begin
            wr_burst <= (wr_burst == LAST_BURST) ? '0 : wr_burst + 17'd1;
            wrapped <= wrapped | (wr_burst == LAST_BURST);
            w_state <= W_IDLE;
          end
      endcase
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= R_IDLE;
      u_rreq <= 1'b0;
      u_radr <= '0;
      h_rbusy <= 1'b0;
      h_rd_en <= 1'b0;
      h_rd_da <= '0;
      r_beat <= '0;
      rd_en_q <= 1'b0;
    end else begin
      h_rd_en <= (r_state == R_DATA) & u_rd_da_en;
      rd_en_q <= (r_state == R_DATA) & u_rd_da_en;
      case (r_state)
        R_IDLE:
          if (h_rreq) begin
            u_radr <= burst_addr(h_rburst);
            u_rreq <= 1'b1;
            h_rbusy <= 1'b1;
            r_state <= R_REQ;
          end
        R_REQ:
          if (u_rack) begin
            u_rreq <= 1'b0;
            r_beat <= '0;
            r_state <= R_DATA;
          end
        R_DATA: begin
          if (u_rd_da_en) begin
            h_rd_da <= u_rd_da;
            r_beat <= r_beat + 3'd1;
          end
          // a short read window ends the transfer on its falling edge
          if ((u_rd_da_en && r_beat == 3'(BURST_LEN - 1)) || (rd_en_q && !u_rd_da_en)) begin
            h_rbusy <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
endmodule

// File: tb/tb_sdram_sample_buf.sv
// tb_sdram_sample_buf: randomized bench with a queue-based ring-buffer model acting as sdram_ctrl.
module tb_sdram_sample_buf;
  localparam int DEPTH = 32;
  localparam int RING = 4;
  logic clk = 0, reset_n = 0, s_valid = 0, clr = 0, h_rreq = 0;
  logic u_wack = 0, u_wr_da_en = 0, u_rack = 0, u_rd_da_en = 0;
  logic [15:0] s_data = '0, u_rd_da = '0;
  logic [16:0] h_rburst = '0;
  logic h_rbusy, h_rd_en, u_wreq, u_rreq, overflow, wrapped;
  logic [15:0] h_rd_da, u_wr_da;
  logic [19:0] u_wadr, u_radr;
  logic [16:0] wr_burst;
  int checks = 0, errors = 0;
  logic [15:0] q[$];
  int exp_wb = 0;
  bit exp_wrapped = 0, exp_ovf = 0;

  sdram_sample_buf #(.FIFO_DEPTH(DEPTH), .RING_BURSTS(RING)) dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_data(s_data), .clr(clr),
    .h_rreq(h_rreq), .h_rburst(h_rburst), .h_rbusy(h_rbusy), .h_rd_en(h_rd_en), .h_rd_da(h_rd_da),
    .u_wreq(u_wreq), .u_wack(u_wack), .u_wr_da_en(u_wr_da_en), .u_wadr(u_wadr), .u_wr_da(u_wr_da),
    .u_rreq(u_rreq), .u_rack(u_rack), .u_radr(u_radr), .u_rd_da_en(u_rd_da_en), .u_rd_da(u_rd_da),
    .wr_burst(wr_burst), .overflow(overflow), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_samples(input int n, input bit rnd, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      s_valid = 1;
      s_data = rnd ? 16'($urandom) : base + 16'(i);
      if (q.size() < DEPTH) q.push_back(s_data);
      else exp_ovf = 1;
      step();
    end
    s_valid = 0;
  endtask

  task automatic write_burst(input int extra, input int clr_beat);
    int t;
    logic [15:0] w;
    t = 0;
    while (u_wreq !== 1'b1 && t < 100) begin
      step();
      t++;
    end
    checks++;
    if (u_wreq !== 1'b1) begin
      $display("FAIL wreq_timeout got %b want 1", u_wreq);
      errors++;
      return;
    end
    checks++;
    if (u_wadr !== 20'(exp_wb * 8)) begin
      $display("FAIL wadr got %h want %h", u_wadr, 20'(exp_wb * 8));
      errors++;
    end
    repeat ($urandom_range(0, 3)) step();
    u_wack = 1;
    step();
    u_wack = 0;
    checks++;
    if (u_wreq !== 1'b0) begin
      $display("FAIL wreq_drop got %b want 0", u_wreq);
      errors++;
    end
    for (int b = 0; b < 8 + extra; b++) begin
      u_wr_da_en = 1;
      clr = (b == clr_beat);
      if (b < 8) begin
        w = q.pop_front();
        checks++;
        if (u_wr_da !== w) begin
          $display("FAIL wr_da beat %0d got %h want %h", b, u_wr_da, w);
          errors++;
        end
      end
      step();
    end
    u_wr_da_en = 0;
    clr = 0;
    if (exp_wb == RING - 1) exp_wrapped = 1;
    exp_wb = (exp_wb + 1) % RING;
    if (clr_beat >= 0) begin
      q.delete();
      exp_wb = 0;
      exp_wrapped = 0;
      exp_ovf = 0;
    end
    step();
    step();
    checks++;
    if (wr_burst !== 17'(exp_wb) || wrapped !== exp_wrapped || overflow !== exp_ovf) begin
      $display("FAIL post_burst got wb=%0d wrap=%b ovf=%b want wb=%0d wrap=%b ovf=%b",
               wr_burst, wrapped, overflow, exp_wb, exp_wrapped, exp_ovf);
      errors++;
    end
  endtask

  task automatic read_burst(input logic [16:0] bi, input logic [15:0] base, input int n, input bit keep_w);
    bit dropped = 0;
    h_rreq = 1;
    h_rburst = bi;
    step();
    h_rreq = 0;
    checks++;
    if (u_rreq !== 1'b1 || h_rbusy !== 1'b1 || u_radr !== (20'(bi) << 3)) begin
      $display("FAIL rreq got rreq=%b busy=%b radr=%h want 1 1 %h", u_rreq, h_rbusy, u_radr, 20'(bi) << 3);
      errors++;
    end
    repeat ($urandom_range(0, 3)) begin
      if (keep_w && u_wreq !== 1'b1) dropped = 1;
      step();
    end
    u_rack = 1;
    step();
    u_rack = 0;
    checks++;
    if (u_rreq !== 1'b0) begin
      $display("FAIL rreq_drop got %b want 0", u_rreq);
      errors++;
    end
    for (int i = 0; i <= n; i++) begin
      u_rd_da_en = (i < n);
      u_rd_da = base + 16'(i);
      if (i > 0) begin
        checks++;
        if (h_rd_en !== 1'b1 || h_rd_da !== base + 16'(i - 1)) begin
          $display("FAIL rd_beat %0d got en=%b da=%h want 1 %h", i - 1, h_rd_en, h_rd_da, base + 16'(i - 1));
          errors++;
        end
      end
      if (keep_w && u_wreq !== 1'b1) dropped = 1;
      step();
    end
    u_rd_da_en = 0;
    checks++;
    if (h_rd_en !== 1'b0 || h_rbusy !== 1'b0) begin
      $display("FAIL rd_end got en=%b busy=%b want 0 0", h_rd_en, h_rbusy);
      errors++;
    end
    if (keep_w) begin
      checks++;
      if (dropped) begin
        $display("FAIL wreq_hold got dropped want held");
        errors++;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({h_rbusy, h_rd_en, h_rd_da, u_wreq, u_wadr, u_wr_da, u_rreq, u_radr, wr_burst, overflow, wrapped} !== '0
        || dut.count !== '0) begin
      $display("FAIL %s got busy=%b rd_en=%b wreq=%b rreq=%b wb=%0d ovf=%b wrap=%b cnt=%0d want all 0",
               tag, h_rbusy, h_rd_en, u_wreq, u_rreq, wr_burst, overflow, wrapped, dut.count);
      errors++;
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    check_zero("reset");
    reset_n = 1;
    step();
    check_zero("after_reset");
  endtask

  task automatic test_basic_burst();
    push_samples(8, 0, 16'h0000);
    write_burst(0, -1);
  endtask

  task automatic test_overflow();
    push_samples(40, 0, 16'h0100);
    repeat (200) step();
    checks++;
    if (overflow !== 1'b1 || int'(dut.count) !== DEPTH) begin
      $display("FAIL overflow got ovf=%b cnt=%0d want 1 %0d", overflow, dut.count, DEPTH);
      errors++;
    end
    repeat (4) write_burst($urandom_range(0, 2), -1);
  endtask

  task automatic test_read();
    read_burst(17'h00003, 16'h00A0, 8, 0);
  endtask

  task automatic test_concurrent();
    push_samples(8, 1, 16'h0);
    read_burst(17'h1ABCD, 16'h5000, 8, 1);
    write_burst(0, -1);
  endtask

  task automatic test_clr();
    push_samples(16, 1, 16'h0);
    write_burst(1, 3);
    checks++;
    if (dut.count !== '0 || u_wreq !== 1'b0) begin
      $display("FAIL clr_empty got cnt=%0d wreq=%b want 0 0", dut.count, u_wreq);
      errors++;
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 5; k++) begin
      push_samples(8, 1, 16'h0);
      write_burst(0, -1);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      push_samples($urandom_range(8, 20), 1, 16'h0);
      while (q.size() >= 8) write_burst($urandom_range(0, 2), -1);
      read_burst(17'($urandom), 16'($urandom), $urandom_range(1, 8), 0);
    end
  endtask

  task automatic test_async_reset();
    int t;
    push_samples(8, 1, 16'h0);
    t = 0;
    while (u_wreq !== 1'b1 && t < 100) begin
      step();
      t++;
    end
    u_wack = 1;
    step();
    u_wack = 0;
    u_wr_da_en = 1;
    h_rreq = 1;
    step();
    h_rreq = 0;
    step();
    #2 reset_n = 0;
    #1 check_zero("async_reset");
    u_wr_da_en = 0;
    q.delete();
    exp_wb = 0;
    exp_wrapped = 0;
    exp_ovf = 0;
    step();
    reset_n = 1;
    step();
    check_zero("after_async_reset");
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_overflow();
    test_read();
    test_concurrent();
    test_clr();
    test_wrap();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
